debug_frame_receiver: RTL and testbench
=======================================

# debug_frame_receiver

Serial-to-parallel receiver for the 26-bit debug status frame emitted by the debug frame serializer (start `1111`, 4-bit key counter, 7-bit message counter, 7-bit ciphertext counter, end `1001`, MSB first, qualified by a frame flag). It sits directly downstream of the serializer, typically in the bring-up/loopback harness or on a second die-side debug path. It hunts for the start sequence, deserialises the payload, checks the end sequence, and presents the three counters in parallel with a one-cycle valid strobe and error accounting.

## Interface
- `FRAME_LEN`, 26, total frame bits including start and end sequences
- `CNT_W`, 8, width of the good-frame and error-frame statistics counters
- `clk` in 1, system clock; all logic on rising edge
- `rst_n` in 1, reset, asynchronous, active-low
- `ena` in 1, block enable; low forces HUNT, no pulses
- `serial_in` in 1, serial frame bit (the serializer's data output)
- `serial_valid` in 1, frame flag; a bit is sampled only when high
- `key_count` out 4, last good frame key counter
- `msg_count` out 7, last good frame message counter
- `ct_count` out 7, last good frame ciphertext counter
- `frame_valid` out 1, one-cycle pulse, new good frame on outputs
- `frame_error` out 1, one-cycle pulse, frame rejected
- `good_frames` out CNT_W, count of good frames, wraps modulo 2^CNT_W
- `err_frames` out CNT_W, count of rejected frames, saturates at all-ones

## Operation
- Sampled bit = `serial_in` on an edge where `ena && serial_valid`.
- States: HUNT, PAYLOAD.
- HUNT: shift sampled bits into a 4-bit window; when window reaches `1111`, go to PAYLOAD with bit index 0. Window clears whenever `serial_valid` is low, so the start sequence must be four consecutive sampled bits.
- PAYLOAD: shift sampled bits into a 22-bit register, index 0..21. At the 22nd sampled bit: if bits[3:0] == `1001`, latch key = bits[21:18], msg = bits[17:11], ct = bits[10:4], pulse `frame_valid`, increment `good_frames`; else pulse `frame_error`, increment `err_frames`, leave count outputs unchanged. Either way return to HUNT with window cleared.
- `serial_valid` low in PAYLOAD (with `ena` high): abort, pulse `frame_error`, increment `err_frames`, return to HUNT.
- `ena` low: HUNT, window and index cleared, no pulses, all outputs held.
- Key field starting with 1s is not ambiguous: the first `1111` after the flag rises always begins the frame; no re-sync inside PAYLOAD.
- Error counter saturates at 2^CNT_W-1; good counter wraps to 0.

## Timing
- Reset: state HUNT, window 0, index 0; `key_count`, `msg_count`, `ct_count`, `good_frames`, `err_frames` = 0; `frame_valid`, `frame_error` = 0.
- All outputs registered. `frame_valid`/`frame_error` and updated counts/statistics appear on the edge that samples the final (26th) bit, visible the following cycle; high exactly one cycle.
- Abort error pulse is asserted on the edge where `serial_valid` is first seen low in PAYLOAD.
- Back-to-back frames: HUNT is entered on the same edge as the final bit, so a start bit on the very next cycle is accepted (zero-gap throughput, 26 cycles/frame).
- `frame_valid` and `frame_error` are never high together.
- Reset mid-frame: immediate return to reset values; partial frame discarded, not counted.

## Structure
- Package `debug_frame_pkg`: START_SEQ = 4'b1111, END_SEQ = 4'b1001, FRAME_LEN, field widths (4/7/7) and field bit offsets, state enum {HUNT, PAYLOAD}; shared with the serializer.
- One sub-module natural: `frame_sipo`, a parameterised serial-in/parallel-out shift register with shift-enable and synchronous clear, used for both the start window and payload.

## Test plan
- Good frame key=4'hA, msg=7'h55, ct=7'h2A (bits 1111 1010 1010101 0101010 1001), flag high 26 cycles -> `frame_valid` one cycle, outputs A/55/2A, `good_frames`=1.
- Same frame with end `1011` -> `frame_error` one cycle, outputs still reset values, `err_frames`=1.
- Flag dropped after 10 bits of a frame -> `frame_error` on drop edge; next complete frame key=4'h3, msg=7'h01, ct=7'h7F decoded correctly.
- Two good frames with zero gap (flag high 52 cycles) -> two `frame_valid` pulses 26 cycles apart, `good_frames`=2.
- Key=4'hF (start followed by 1111) -> decodes key=F, not mis-synchronised; `ena` low mid-frame -> no pulse, counters unchanged.
- 256 bad frames with CNT_W=8 -> `err_frames` stays 255; `rst_n` low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/debug_frame_pkg.sv
// rtl/debug_frame_pkg.sv - shared constants and types for the debug status frame
package debug_frame_pkg;

  localparam int FRAME_LEN = 26;
  localparam int SEQ_W     = 4;
  localparam logic [SEQ_W-1:0] START_SEQ = 4'b1111;
  localparam logic [SEQ_W-1:0] END_SEQ   = 4'b1001;

  localparam int KEY_W = 4;
  localparam int MSG_W = 7;
  localparam int CT_W  = 7;

  // Field offsets inside the 22-bit payload word (end sequence in the low bits)
  localparam int CT_LSB  = SEQ_W;
  localparam int MSG_LSB = CT_LSB + CT_W;
  localparam int KEY_LSB = MSG_LSB + MSG_W;

  typedef enum logic {HUNT, PAYLOAD} state_e;

endpackage

// File: rtl/frame_sipo.sv
// rtl/frame_sipo.sv - serial-in/parallel-out shift register, MSB first, with sync clear
module frame_sipo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] data
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (shift_en) begin
      data_d = {data_q[W-2:0], bit_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/debug_frame_receiver.sv
// rtl/debug_frame_receiver.sv - hunts for the debug frame start, deserialises and checks it
module debug_frame_receiver #(
  parameter int FRAME_LEN = debug_frame_pkg::FRAME_LEN,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [3:0]       key_count,
  output logic [6:0]       msg_count,
  output logic [6:0]       ct_count,
  output logic             frame_valid,
  output logic             frame_error,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] err_frames
);

  import debug_frame_pkg::*;

  localparam int PAY_LEN = FRAME_LEN - SEQ_W;
  localparam int IDX_W   = $clog2(PAY_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [CT_W-1:0]  ct_q, ct_d;
  logic             fv_q, fv_d;
  logic             fe_q, fe_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] err_inc;

  // The current bit completes both windows, so the registers hold one bit less
  logic [SEQ_W-2:0]   win;
  logic [PAY_LEN-2:0] pay;
  logic [SEQ_W-1:0]   win_now;
  logic [PAY_LEN-1:0] word;
  logic               win_clr, win_shift, pay_clr, pay_shift;

  assign win_now = {win, serial_in};
  assign word    = {pay, serial_in};
  assign err_inc = (err_q == '1) ? err_q : err_q + CNT_W'(1);

  frame_sipo #(.W(SEQ_W - 1)) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .shift_en (win_shift),
    .bit_in   (serial_in),
    .data     (win)
  );

  frame_sipo #(.W(PAY_LEN - 1)) u_pay (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pay_clr),
    .shift_en (pay_shift),
    .bit_in   (serial_in),
    .data     (pay)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    key_d     = key_q;
    msg_d     = msg_q;
    ct_d      = ct_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    good_d    = good_q;
    err_d     = err_q;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    pay_clr   = 1'b0;
    pay_shift = 1'b0;

    if (!ena) begin
      state_d = HUNT;
      idx_d   = '0;
      win_clr = 1'b1;
      pay_clr = 1'b1;
    end else begin
      case (state_q)
        HUNT: begin
          if (!serial_valid) begin
            win_clr = 1'b1;
          end else if (win_now == START_SEQ) begin
            state_d = PAYLOAD;
            idx_d   = '0;
            win_clr = 1'b1;
            pay_clr = 1'b1;
          end else begin
            win_shift = 1'b1;
          end
        end
        PAYLOAD: begin
          win_clr = 1'b1;
          if (!serial_valid) begin
            fe_d    = 1'b1;
            err_d   = err_inc;
            state_d = HUNT;
            idx_d   = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d = HUNT;
            idx_d   = '0;
            if (word[SEQ_W-1:0] == END_SEQ) begin
              key_d  = word[KEY_LSB +: KEY_W];
              msg_d  = word[MSG_LSB +: MSG_W];
              ct_d   = word[CT_LSB +: CT_W];
              fv_d   = 1'b1;
              good_d = good_q + CNT_W'(1);
            end else begin
              fe_d  = 1'b1;
              err_d = err_inc;
            end
          end else begin
            pay_shift = 1'b1;
            idx_d     = idx_q + IDX_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      idx_q   <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      ct_q    <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      good_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      ct_q    <= ct_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  assign key_count   = key_q;
  assign msg_count   = msg_q;
  assign ct_count    = ct_q;
  assign frame_valid = fv_q;
  assign frame_error = fe_q;
  assign good_frames = good_q;
  assign err_frames  = err_q;

endmodule

// File: tb/tb_debug_frame_receiver.sv
// tb/tb_debug_frame_receiver.sv - directed vector bench for debug_frame_receiver
module tb_debug_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       serial_in;
  logic       serial_valid;
  logic [3:0] key_count;
  logic [6:0] msg_count;
  logic [6:0] ct_count;
  logic       frame_valid;
  logic       frame_error;
  logic [7:0] good_frames;
  logic [7:0] err_frames;

  int n_chk = 0;
  int n_err = 0;

  debug_frame_receiver #(.FRAME_LEN(26), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .key_count    (key_count),
    .msg_count    (msg_count),
    .ct_count     (ct_count),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .good_frames  (good_frames),
    .err_frames   (err_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] bits;
    int          n;
    logic        fv;
    logic        fe;
    logic [3:0]  key;
    logic [6:0]  msg;
    logic [6:0]  ct;
    logic [7:0]  good;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [25:0] mk(input logic [3:0] k, input logic [6:0] m,
                                     input logic [6:0] c, input logic [3:0] e);
    return {4'b1111, k, m, c, e};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives the first n bits of f, MSB first, one per cycle with the flag high
  task automatic send_bits(input logic [25:0] f, input int n);
    for (int b = 25; b > 25 - n; b--) begin
      @(negedge clk);
      serial_valid = 1'b1;
      serial_in    = f[b];
    end
  endtask

  logic [25:0] fa, fb, bad;
  logic [51:0] bb;
  int          pulses, p1, p2;
  logic [7:0]  exp_good, exp_err;

  initial begin
    rst_n = 1'b0; ena = 1'b1; serial_in = 1'b0; serial_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset outputs", {8'h0, key_count, msg_count, ct_count, frame_valid, frame_error},
        32'h0);
    chk("reset stats", {16'h0, good_frames, err_frames}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{mk(4'hA, 7'h55, 7'h2A, 4'b1011), 26, 1'b0, 1'b1, 4'h0, 7'h00, 7'h00, 8'd0, 8'd1};
    vecs[1] = '{mk(4'hA, 7'h55, 7'h2A, 4'b1001), 26, 1'b1, 1'b0, 4'hA, 7'h55, 7'h2A, 8'd1, 8'd1};
    vecs[2] = '{mk(4'h3, 7'h01, 7'h7F, 4'b1001), 10, 1'b0, 1'b1, 4'hA, 7'h55, 7'h2A, 8'd1, 8'd2};
    vecs[3] = '{mk(4'h3, 7'h01, 7'h7F, 4'b1001), 26, 1'b1, 1'b0, 4'h3, 7'h01, 7'h7F, 8'd2, 8'd2};
    vecs[4] = '{mk(4'hF, 7'h12, 7'h34, 4'b1001), 26, 1'b1, 1'b0, 4'hF, 7'h12, 7'h34, 8'd3, 8'd2};
    vecs[5] = '{26'h0,                           26, 1'b0, 1'b0, 4'hF, 7'h12, 7'h34, 8'd3, 8'd2};

    for (int i = 0; i < 6; i++) begin
      send_bits(vecs[i].bits, vecs[i].n);
      @(negedge clk);
      if (vecs[i].n < 26) begin
        serial_valid = 1'b0;
        @(negedge clk);
      end
      serial_valid = 1'b0;
      chk($sformatf("v%0d valid", i), {31'h0, frame_valid}, {31'h0, vecs[i].fv});
      chk($sformatf("v%0d error", i), {31'h0, frame_error}, {31'h0, vecs[i].fe});
      chk($sformatf("v%0d fields", i), {14'h0, key_count, msg_count, ct_count},
          {14'h0, vecs[i].key, vecs[i].msg, vecs[i].ct});
      chk($sformatf("v%0d stats", i), {16'h0, good_frames, err_frames},
          {16'h0, vecs[i].good, vecs[i].err});
      @(negedge clk);
      chk($sformatf("v%0d pulse width", i), {30'h0, frame_valid, frame_error}, 32'h0);
    end
    exp_good = 8'd3;
    exp_err  = 8'd2;

    // Zero-gap back-to-back frames
    fa = mk(4'h5, 7'h11, 7'h22, 4'b1001);
    fb = mk(4'hC, 7'h7E, 7'h01, 4'b1001);
    bb = {fa, fb};
    pulses = 0; p1 = -1; p2 = -1;
    for (int i = 0; i <= 52; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        pulses++;
        if (pulses == 1) p1 = i;
        else p2 = i;
      end
      if (i == 26) chk("b2b first key", {28'h0, key_count}, 32'h5);
      if (i < 52) begin
        serial_valid = 1'b1;
        serial_in    = bb[51 - i];
      end else begin
        serial_valid = 1'b0;
      end
    end
    exp_good = exp_good + 8'd2;
    chk("b2b pulse count", pulses, 2);
    chk("b2b first pos", p1, 26);
    chk("b2b second pos", p2, 52);
    chk("b2b fields", {14'h0, key_count, msg_count, ct_count}, {14'h0, 4'hC, 7'h7E, 7'h01});
    chk("b2b stats", {16'h0, good_frames, err_frames}, {16'h0, exp_good, exp_err});

    // ena low mid-frame: silent abandon
    send_bits(mk(4'h6, 7'h33, 7'h44, 4'b1001), 9);
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ena low pulses", {30'h0, frame_valid, frame_error}, 32'h0);
      chk("ena low stats", {16'h0, good_frames, err_frames}, {16'h0, exp_good, exp_err});
    end
    ena = 1'b1;
    serial_valid = 1'b0;
    send_bits(mk(4'h7, 7'h0A, 7'h0B, 4'b1001), 26);
    @(negedge clk);
    serial_valid = 1'b0;
    exp_good = exp_good + 8'd1;
    chk("after ena valid", {31'h0, frame_valid}, 32'h1);
    chk("after ena fields", {14'h0, key_count, msg_count, ct_count},
        {14'h0, 4'h7, 7'h0A, 7'h0B});
    chk("after ena stats", {16'h0, good_frames, err_frames}, {16'h0, exp_good, exp_err});

    // 256 back-to-back bad frames saturate the error counter
    bad = mk(4'h1, 7'h02, 7'h03, 4'b0000);
    for (int k = 0; k < 256; k++) send_bits(bad, 26);
    @(negedge clk);
    serial_valid = 1'b0;
    chk("sat last error", {31'h0, frame_error}, 32'h1);
    chk("sat err count", {24'h0, err_frames}, 32'hFF);
    chk("sat good count", {24'h0, good_frames}, {24'h0, exp_good});
    chk("sat fields kept", {14'h0, key_count, msg_count, ct_count},
        {14'h0, 4'h7, 7'h0A, 7'h0B});

    // Asynchronous reset in the middle of a frame
    send_bits(mk(4'h9, 7'h19, 7'h29, 4'b1001), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset outputs", {8'h0, key_count, msg_count, ct_count, frame_valid, frame_error},
        32'h0);
    chk("mid reset stats", {16'h0, good_frames, err_frames}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    serial_valid = 1'b0;
    send_bits(mk(4'h2, 7'h40, 7'h08, 4'b1001), 26);
    @(negedge clk);
    serial_valid = 1'b0;
    chk("post reset fields", {14'h0, key_count, msg_count, ct_count},
        {14'h0, 4'h2, 7'h40, 7'h08});
    chk("post reset stats", {16'h0, good_frames, err_frames}, {16'h0, 8'd1, 8'd0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
